// File: rtl/sys_clk_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sys_clk_timer_sequencer
//  Description : Avalon-MM master that programs the interval timer from
//                valid/ready config requests and services its timeout irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_clk_timer_sequencer #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] MIN_PERIOD = 32'd2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_enable,
    input  logic             cfg_continuous,
    input  logic [31:0]      cfg_period,
    output logic             cfg_done,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    input  logic             tmr_irq,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_W_STOP    = 3'd1;
    localparam logic [2:0] c_W_PL      = 3'd2;
    localparam logic [2:0] c_W_PH      = 3'd3;
    localparam logic [2:0] c_W_CLR     = 3'd4;
    localparam logic [2:0] c_W_START   = 3'd5;
    localparam logic [2:0] c_W_ACK     = 3'd6;
    localparam logic [2:0] c_ACK_GUARD = 3'd7;

    logic [2:0]       state_q,          state_d;
    logic [31:0]      period_q,         period_d;
    logic             enable_q,         enable_d;
    logic             cont_q,           cont_d;
    logic [CNT_W-1:0] tick_count_q,     tick_count_d;
    logic             tick_q,           tick_d;
    logic             cfg_done_q,       cfg_done_d;
    logic [2:0]       tmr_address_q,    tmr_address_d;
    logic             tmr_chipselect_q, tmr_chipselect_d;
    logic             tmr_write_n_q,    tmr_write_n_d;
    logic [15:0]      tmr_writedata_q,  tmr_writedata_d;

    logic             w_cfg_fire;
    logic [31:0]      w_period_clamped;

    assign cfg_ready        = (state_q == c_IDLE) && !tmr_irq;
    assign w_cfg_fire       = cfg_valid && cfg_ready;
    assign w_period_clamped = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;

    always_comb begin
        state_d          = state_q;
        period_d         = period_q;
        enable_d         = enable_q;
        cont_d           = cont_q;
        tick_count_d     = tick_count_q;
        tick_d           = 1'b0;
        cfg_done_d       = 1'b0;
        tmr_address_d    = 3'd0;
        tmr_chipselect_d = 1'b0;
        tmr_write_n_d    = 1'b1;
        tmr_writedata_d  = 16'h0000;

        case (state_q)
            c_IDLE: begin
                if (tmr_irq) begin
                    state_d = c_W_ACK;
                end else if (w_cfg_fire) begin
                    state_d  = c_W_STOP;
                    period_d = w_period_clamped;
                    enable_d = cfg_enable;
                    cont_d   = cfg_continuous;
                end
            end
            c_W_STOP:    state_d = enable_q ? c_W_PL : c_W_CLR;
            c_W_PL:      state_d = c_W_PH;
            c_W_PH:      state_d = c_W_CLR;
            c_W_CLR:     state_d = enable_q ? c_W_START : c_IDLE;
            c_W_START:   state_d = c_IDLE;
            c_W_ACK:     state_d = c_ACK_GUARD;
            c_ACK_GUARD: state_d = c_IDLE;
            default:     state_d = c_IDLE;
        endcase

        // Bus outputs are decoded from the next state so each write lands
        // in the same cycle the FSM occupies the matching state.
        case (state_d)
            c_W_STOP: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                tmr_address_d    = 3'd1;
                tmr_writedata_d  = 16'h0008;
            end
            c_W_PL: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                tmr_address_d    = 3'd2;
                tmr_writedata_d  = period_q[15:0];
            end
            c_W_PH: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                tmr_address_d    = 3'd3;
                tmr_writedata_d  = period_q[31:16];
            end
            c_W_CLR: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                cfg_done_d       = !enable_q;
            end
            c_W_START: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                tmr_address_d    = 3'd1;
                tmr_writedata_d  = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
                cfg_done_d       = 1'b1;
            end
            c_W_ACK: begin
                tmr_chipselect_d = 1'b1;
                tmr_write_n_d    = 1'b0;
                tick_d           = 1'b1;
                tick_count_d     = tick_count_q + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= c_IDLE;
            period_q         <= 32'd0;
            enable_q         <= 1'b0;
            cont_q           <= 1'b0;
            tick_count_q     <= '0;
            tick_q           <= 1'b0;
            cfg_done_q       <= 1'b0;
            tmr_address_q    <= 3'd0;
            tmr_chipselect_q <= 1'b0;
            tmr_write_n_q    <= 1'b1;
            tmr_writedata_q  <= 16'h0000;
        end else begin
            state_q          <= state_d;
            period_q         <= period_d;
            enable_q         <= enable_d;
            cont_q           <= cont_d;
            tick_count_q     <= tick_count_d;
            tick_q           <= tick_d;
            cfg_done_q       <= cfg_done_d;
            tmr_address_q    <= tmr_address_d;
            tmr_chipselect_q <= tmr_chipselect_d;
            tmr_write_n_q    <= tmr_write_n_d;
            tmr_writedata_q  <= tmr_writedata_d;
        end
    end

    assign busy           = (state_q != c_IDLE);
    assign tick           = tick_q;
    assign tick_count     = tick_count_q;
    assign cfg_done       = cfg_done_q;
    assign tmr_address    = tmr_address_q;
    assign tmr_chipselect = tmr_chipselect_q;
    assign tmr_write_n    = tmr_write_n_q;
    assign tmr_writedata  = tmr_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_clk_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_clk_timer_sequencer
//  Description : Directed, table-driven bench for sys_clk_timer_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_clk_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_enable;
    logic        cfg_continuous;
    logic [31:0] cfg_period;
    logic        tmr_irq;

    logic        cfg_ready, cfg_done, busy, tick;
    logic [31:0] tick_count;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata;

    // Narrow-counter instance so the tick_count wrap is reachable quickly.
    logic        n_cfg_ready, n_cfg_done, n_busy, n_tick;
    logic [3:0]  n_tick_count;
    logic [2:0]  n_tmr_address;
    logic        n_tmr_chipselect, n_tmr_write_n;
    logic [15:0] n_tmr_writedata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ticks;

    always #5 clk = ~clk;

    sys_clk_timer_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_enable(cfg_enable),
        .cfg_continuous(cfg_continuous), .cfg_period(cfg_period),
        .cfg_done(cfg_done), .busy(busy), .tick(tick), .tick_count(tick_count),
        .tmr_irq(tmr_irq), .tmr_address(tmr_address),
        .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata)
    );

    sys_clk_timer_sequencer #(.CNT_W(4)) dut_n (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(n_cfg_ready), .cfg_enable(cfg_enable),
        .cfg_continuous(cfg_continuous), .cfg_period(cfg_period),
        .cfg_done(n_cfg_done), .busy(n_busy), .tick(n_tick), .tick_count(n_tick_count),
        .tmr_irq(tmr_irq), .tmr_address(n_tmr_address),
        .tmr_chipselect(n_tmr_chipselect), .tmr_write_n(n_tmr_write_n),
        .tmr_writedata(n_tmr_writedata)
    );

    typedef struct {
        logic [31:0] period;
        logic        en;
        logic        cont;
        logic [15:0] pl;
        logic [15:0] ph;
        logic [15:0] start;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string name, input logic [2:0] a, input logic [15:0] d,
                          input logic done);
        chk({name, "_cs"},   tmr_chipselect, 1);
        chk({name, "_wn"},   tmr_write_n, 0);
        chk({name, "_addr"}, tmr_address, a);
        chk({name, "_data"}, tmr_writedata, d);
        chk({name, "_done"}, cfg_done, done);
    endtask

    task automatic run_cfg(input vec_t v);
        cfg_valid      = 1'b1;
        cfg_period     = v.period;
        cfg_enable     = v.en;
        cfg_continuous = v.cont;
        chk("cfg_ready_idle", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk_wr("stop", 3'd1, 16'h0008, 1'b0);
        chk("busy_seq", busy, 1);
        chk("ready_seq", cfg_ready, 0);
        if (v.en) begin
            step(); chk_wr("pl",    3'd2, v.pl,    1'b0);
            step(); chk_wr("ph",    3'd3, v.ph,    1'b0);
            step(); chk_wr("clr",   3'd0, 16'h0,   1'b0);
            step(); chk_wr("start", 3'd1, v.start, 1'b1);
        end else begin
            step(); chk_wr("clr_dis", 3'd0, 16'h0, 1'b1);
        end
        step();
        chk("post_cs",   tmr_chipselect, 0);
        chk("post_wn",   tmr_write_n, 1);
        chk("post_done", cfg_done, 0);
        chk("post_busy", busy, 0);
    endtask

    task automatic do_irq();
        tmr_irq = 1'b1;
        #1;
        chk("irq_ready_low", cfg_ready, 0);
        step();
        exp_ticks = exp_ticks + 1;
        chk_wr("ack", 3'd0, 16'h0, 1'b0);
        chk("ack_tick",   tick, 1);
        chk("ack_count",  tick_count, exp_ticks);
        chk("ack_ready",  cfg_ready, 0);
        chk("n_ack_count", n_tick_count, exp_ticks[3:0]);
        chk("n_ack_bus", {n_tmr_chipselect, n_tmr_write_n, n_tmr_address, n_tmr_writedata},
            {1'b1, 1'b0, 3'd0, 16'h0});
        chk("n_ack_flags", {n_tick, n_cfg_done, n_busy, n_cfg_ready}, 4'b1010);
        step();
        chk("guard_tick",  tick, 0);
        chk("guard_cs",    tmr_chipselect, 0);
        chk("guard_ready", cfg_ready, 0);
        tmr_irq = 1'b0;
        step();
        chk("irq_done_ready", cfg_ready, 1);
        chk("irq_done_tick",  tick, 0);
        chk("irq_done_count", tick_count, exp_ticks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd49999,      1'b1, 1'b1, 16'hC34F, 16'h0000, 16'h0007};
        vecs[1] = '{32'd0,          1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0005};
        vecs[2] = '{32'h0001_86A0,  1'b1, 1'b1, 16'h86A0, 16'h0001, 16'h0007};
        vecs[3] = '{32'd1234,       1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{32'd1,          1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0007};
        vecs[5] = '{32'd2,          1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0005};

        reset_n = 1'b0; cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_continuous = 1'b0;
        cfg_period = 32'd0; tmr_irq = 1'b0; exp_ticks = 32'd0;
        repeat (3) step();
        chk("rst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {1'b0, 1'b1, 3'd0, 16'h0});
        chk("rst_flags", {cfg_done, tick, busy}, 3'b000);
        chk("rst_count", tick_count, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_cfg(vecs[i]);

        do_irq();

        // irq and config request together: ack first, config follows
        cfg_valid = 1'b1; cfg_period = vecs[0].period;
        cfg_enable = vecs[0].en; cfg_continuous = vecs[0].cont;
        do_irq();
        run_cfg(vecs[0]);

        for (int i = 0; i < 14; i++) do_irq();
        chk("n_wrap", n_tick_count, 0);
        chk("count_16", tick_count, 16);

        // reset in the middle of a sequence
        cfg_valid = 1'b1; cfg_period = vecs[0].period;
        cfg_enable = 1'b1; cfg_continuous = 1'b1;
        step(); cfg_valid = 1'b0;
        step();
        step();
        chk("midrst_ph_addr", tmr_address, 3);
        reset_n = 1'b0;
        step();
        exp_ticks = 32'd0;
        chk("midrst_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {1'b0, 1'b1, 3'd0, 16'h0});
        chk("midrst_busy",  busy, 0);
        chk("midrst_count", tick_count, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_nowrite", tmr_chipselect, 0);
        end
        run_cfg(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
